// File: rtl/des_round_ctrl.sv
// DES round sequencer: accepts a block, then steps the datapath through
// IP load, ROUNDS Feistel rounds with key-schedule rotations, FP capture and output handshake.
//
// state   | meaning
// IDLE    | waiting for start_valid; only state with start_ready high
// LOAD    | one cycle of ip_load
// ROUND   | ROUNDS cycles of round_en with key rotation controls
// FINAL   | one cycle of fp_load
// DONE    | out_valid held until out_ready
module des_round_ctrl #(
  parameter int ROUNDS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic       decrypt,
  input  logic       abort,
  output logic       ip_load,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic [1:0] ks_shift,
  output logic       ks_dir,
  output logic       fp_load,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

  state_t     state, state_nxt;
  logic       dir, dir_nxt;
  logic [3:0] rnd_left, rnd_left_nxt;
  logic [3:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      dir      <= 1'b0;
      rnd_left <= 4'd0;
    end else begin
      state    <= state_nxt;
      dir      <= dir_nxt;
      rnd_left <= rnd_left_nxt;
    end
  end

  // rnd_left counts down to the terminal round; abort wins everywhere
  always_comb begin
    state_nxt    = state;
    dir_nxt      = dir;
    rnd_left_nxt = rnd_left;
    case (state)
      S_IDLE: begin
        if (start_valid && !abort) begin
          state_nxt = S_LOAD;
          dir_nxt   = decrypt;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt    = S_ROUND;
          rnd_left_nxt = LAST_IDX;
        end
      end
      S_ROUND: begin
        if (abort) begin
          state_nxt    = S_IDLE;
          rnd_left_nxt = 4'd0;
        end else if (rnd_left == 4'd0) begin
          state_nxt = S_FINAL;
        end else begin
          rnd_left_nxt = rnd_left - 4'd1;
        end
      end
      S_FINAL: begin
        state_nxt = abort ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        if (abort || out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign start_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign ip_load     = (state == S_LOAD);
  assign round_en    = (state == S_ROUND);
  assign fp_load     = (state == S_FINAL);
  assign out_valid   = (state == S_DONE);
  assign idx         = LAST_IDX - rnd_left;

  // Decrypt walks the encrypt schedule backwards, so its first round needs no rotation
  always_comb begin
    round_idx = 4'd0;
    ks_shift  = 2'd0;
    ks_dir    = 1'b0;
    if (round_en) begin
      round_idx = idx;
      ks_dir    = dir;
      if (dir && idx == 4'd0)
        ks_shift = 2'd0;
      else if (idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15)
        ks_shift = 2'd1;
      else
        ks_shift = 2'd2;
    end
  end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Scoreboard bench for des_round_ctrl: stimulus pushes expected block traces,
// a negedge monitor rebuilds each observed trace and compares on out_valid.
module tb_des_round_ctrl;

  localparam int R = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_valid = 1'b0;
  logic       decrypt = 1'b0;
  logic       abort = 1'b0;
  logic       out_ready = 1'b0;
  logic       start_ready, ip_load, round_en, ks_dir, fp_load, out_valid, busy;
  logic [3:0] round_idx;
  logic [1:0] ks_shift;

  des_round_ctrl #(.ROUNDS(R)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .decrypt(decrypt), .abort(abort), .ip_load(ip_load), .round_en(round_en),
    .round_idx(round_idx), .ks_shift(ks_shift), .ks_dir(ks_dir), .fp_load(fp_load),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dir;
    int          lat;
    int          nr;
    logic [31:0] seq;
    int          sum;
  } exp_t;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } dchk_t;

  exp_t  sbq[$];
  dchk_t dq[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;

  // Standard DES left-rotation schedule for encryption rounds 1..16
  int des_shift[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Decryption undoes the encrypt rotations in reverse order, starting from C16/D16 = C0/D0
  function automatic exp_t model(logic d);
    exp_t e;
    e.dir = d;
    e.lat = R + 3;
    e.nr  = R;
    e.seq = '0;
    e.sum = 0;
    for (int i = 0; i < R; i++) begin
      int s;
      s = d ? ((i == 0) ? 0 : des_shift[16 - i]) : des_shift[i];
      e.seq[2*i +: 2] = 2'(s);
      e.sum += s;
    end
    return e;
  endfunction

  function automatic void chk(string n, int a, int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", n, a, e, cyc);
    end
  endfunction

  // Monitor: sole owner of the pass/fail counters
  int          nr, ipc, fpc, sum, dones, acc_cyc;
  logic [31:0] seq;
  logic        ov_prev = 1'b0;

  always @(negedge clk) begin
    exp_t  e;
    dchk_t d;
    cyc++;
    while (dq.size() > 0) begin
      d = dq.pop_front();
      chk(d.name, d.act, d.exp);
    end
    chk("onehot", int'($countones({ip_load, round_en, fp_load, out_valid}) <= 1), 1);
    chk("ready_vs_busy", int'(start_ready), int'(!busy));
    chk("strobe_without_busy", int'((ip_load | round_en | fp_load | out_valid) & !busy), 0);
    chk("ks_outside_round", int'(!round_en && (round_idx != 4'd0 || ks_shift != 2'd0 || ks_dir)), 0);
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (ip_load) ipc++;
      if (fp_load) begin
        fpc++;
        chk("fp_load_expected", int'(sbq.size() > 0), 1);
      end
      if (round_en) begin
        chk("round_idx_step", int'(round_idx), nr);
        if (nr < 16) seq[2*nr +: 2] = ks_shift;
        sum += int'(ks_shift);
        if (ks_dir) dones++;
        nr++;
      end
      if (out_valid && !ov_prev) begin
        chk("sb_nonempty_at_valid", int'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("latency", cyc - acc_cyc, e.lat);
          chk("round_count", nr, e.nr);
          chk("shift_seq", int'(seq), int'(e.seq));
          chk("shift_sum", sum, e.sum);
          chk("ks_dir_rounds", dones, e.dir ? e.nr : 0);
          chk("ip_load_cycles", ipc, 1);
          chk("fp_load_cycles", fpc, 1);
        end
      end
      ov_prev = out_valid;
      if (start_valid && start_ready && !abort) begin
        acc_cyc = cyc;
        nr = 0; ipc = 0; fpc = 0; sum = 0; dones = 0; seq = '0;
      end
    end
  end

  task automatic dchk(string n, int a, int e);
    dq.push_back('{name: n, act: a, exp: e});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (start_ready) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
    dchk("timeout_start_ready", 0, 1);
  endtask

  // Full block; decrypt is scrambled after accept to show it is ignored
  task automatic run_block(input logic d, input int bp, input bit abort_done);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    out_ready = (bp == 0 && !abort_done);
    sbq.push_back(model(d));
    start_valid = 1'b1;
    decrypt = d;
    tick();
    start_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < R + 10; i++) begin
      decrypt = 1'($urandom);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      dchk("timeout_out_valid", 0, 1);
      return;
    end
    for (int i = 0; i < bp; i++) begin
      start_valid = 1'($urandom);
      tick();
      dchk("bp_valid_held", int'(out_valid), 1);
      dchk("bp_no_start_ready", int'(start_ready), 0);
    end
    if (abort_done) begin
      start_valid = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      dchk("abort_done_valid_drop", int'(out_valid), 0);
      dchk("abort_done_idle", int'(start_ready), 1);
    end else begin
      start_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      start_valid = 1'b0;
      out_ready = 1'b0;
      dchk("hs_ready_next", int'(start_ready), 1);
      dchk("hs_valid_low", int'(out_valid), 0);
    end
  endtask

  // Start a block that must never complete, and return once it reaches round idx
  task automatic start_to_round(input logic d, input int idx, output bit found);
    bit ok;
    found = 1'b0;
    wait_ready(ok);
    if (!ok) return;
    start_valid = 1'b1;
    decrypt = d;
    tick();
    start_valid = 1'b0;
    for (int i = 0; i < R + 5; i++) begin
      decrypt = 1'($urandom);
      if (round_en && int'(round_idx) == idx) begin
        found = 1'b1;
        return;
      end
      tick();
    end
    dchk("timeout_round_idx", 0, 1);
  endtask

  initial begin
    bit found;
    tick();
    tick();
    dchk("rst_start_ready", int'(start_ready), 1);
    dchk("rst_busy", int'(busy), 0);
    dchk("rst_strobes", int'({ip_load, round_en, fp_load, out_valid}), 0);
    dchk("rst_ks", int'({round_idx, ks_shift, ks_dir}), 0);
    rst_n = 1'b1;
    tick();

    run_block(1'b0, 0, 1'b0);
    run_block(1'b1, 0, 1'b0);
    run_block(1'b0, 5, 1'b0);

    start_to_round(1'b0, 7, found);
    if (found) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      dchk("abort_r7_idle", int'(start_ready), 1);
      dchk("abort_r7_idx", int'(round_idx), 0);
      dchk("abort_r7_no_fp", int'(fp_load), 0);
      repeat (R + 4) tick();
    end
    run_block(1'b1, 0, 1'b0);

    start_to_round(1'b1, 10, found);
    if (found) begin
      #2;
      rst_n = 1'b0;
      #1;
      dchk("rst_mid_round_en", int'(round_en), 0);
      dchk("rst_mid_busy", int'(busy), 0);
      dchk("rst_mid_ready", int'(start_ready), 1);
      dchk("rst_mid_ks", int'({round_idx, ks_shift, ks_dir}), 0);
      tick();
      tick();
      rst_n = 1'b1;
    end
    run_block(1'b0, 1, 1'b0);

    abort = 1'b1;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    abort = 1'b0;
    dchk("abort_idle_no_accept", int'(busy), 0);
    run_block(1'b1, 2, 1'b1);

    for (int k = 0; k < 10; k++) begin
      run_block(1'($urandom), int'($urandom_range(0, 4)), 1'b0);
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    dchk("sb_empty_at_end", sbq.size(), 0);
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
